// File: rtl/regfile_arbiter_pkg.sv
// Shared types and defaults for the register-file arbiter and its dump engine.
// Optional debug write port is enabled with REGFILE_ARB_DBG_WRITE_EN.
package regfile_arbiter_pkg;

   localparam int NB_DATA_DEF = 32;
   localparam int NB_ADDR_DEF = 5;
   localparam int N_REGS_DEF  = 32;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_READ = 3'd2,
      ST_HOLD = 3'd3,
      ST_DONE = 3'd4
   } dump_state_t;

   // r0 is hardwired to zero in MIPS, so any write aimed at it is dropped.
   function automatic logic write_allowed(input logic [31:0] index);
      return (index != 32'd0);
   endfunction

endpackage

// File: rtl/regfile_arbiter_if.sv
// Debug-unit side of the register-file arbiter: dump handshake and, with
// REGFILE_ARB_DBG_WRITE_EN, the debug write request channel.
interface regfile_arbiter_if
   import regfile_arbiter_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_ADDR = NB_ADDR_DEF
);

   logic               dbg_dump_start;
   logic               dbg_busy;
   logic               dbg_valid;
   logic               dbg_ready;
   logic [NB_ADDR-1:0] dbg_addr;
   logic [NB_DATA-1:0] dbg_data;
   logic               dbg_done;
`ifdef REGFILE_ARB_DBG_WRITE_EN
   logic               dbg_wr_req;
   logic [NB_ADDR-1:0] dbg_wr_addr;
   logic [NB_DATA-1:0] dbg_wr_data;
   logic               dbg_wr_ack;

   modport master (
      output dbg_dump_start, dbg_ready, dbg_wr_req, dbg_wr_addr, dbg_wr_data,
      input  dbg_busy, dbg_valid, dbg_addr, dbg_data, dbg_done, dbg_wr_ack
   );
   modport slave (
      input  dbg_dump_start, dbg_ready, dbg_wr_req, dbg_wr_addr, dbg_wr_data,
      output dbg_busy, dbg_valid, dbg_addr, dbg_data, dbg_done, dbg_wr_ack
   );
`else
   modport master (
      output dbg_dump_start, dbg_ready,
      input  dbg_busy, dbg_valid, dbg_addr, dbg_data, dbg_done
   );
   modport slave (
      input  dbg_dump_start, dbg_ready,
      output dbg_busy, dbg_valid, dbg_addr, dbg_data, dbg_done
   );
`endif

endinterface

// File: rtl/regfile_dump_fsm.sv
// Dump engine: halts the pipeline, then streams r0..N_REGS-1 to the debug
// unit one word per valid/ready handshake.
module regfile_dump_fsm
   import regfile_arbiter_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_ADDR = NB_ADDR_DEF,
   parameter int N_REGS  = N_REGS_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall_ack,
   input  logic               dump_start,
   input  logic               ready,
   input  logic [NB_DATA-1:0] rf_read_data,
   output logic               stall_req,
   output logic               busy,
   output logic               valid,
   output logic               done,
   output logic               idle,
   output logic               dump_read,
   output logic [NB_ADDR-1:0] idx,
   output logic [NB_ADDR-1:0] addr,
   output logic [NB_DATA-1:0] data
);

   localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(N_REGS - 1);
   localparam logic [NB_ADDR-1:0] ONE_IDX  = NB_ADDR'(1);

   dump_state_t state;

   assign idle      = (state == ST_IDLE);
   assign dump_read = (state == ST_READ) || (state == ST_HOLD);

   // Dump sequencer with all handshake outputs registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         idx       <= {NB_ADDR{1'b0}};
         stall_req <= 1'b0;
         busy      <= 1'b0;
         valid     <= 1'b0;
         done      <= 1'b0;
         addr      <= {NB_ADDR{1'b0}};
         data      <= {NB_DATA{1'b0}};
      end else begin
         case (state)
            ST_IDLE: begin
               if (dump_start) begin
                  state     <= ST_REQ;
                  stall_req <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            ST_REQ: begin
               if (stall_ack) begin
                  state <= ST_READ;
               end
            end
            ST_READ: begin
               data  <= rf_read_data;
               addr  <= idx;
               valid <= 1'b1;
               state <= ST_HOLD;
            end
            ST_HOLD: begin
               // Word stays frozen until the debug unit takes it.
               if (valid && ready) begin
                  valid <= 1'b0;
                  if (idx == LAST_IDX) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     idx   <= idx + ONE_IDX;
                     state <= ST_READ;
                  end
               end
            end
            ST_DONE: begin
               done      <= 1'b0;
               stall_req <= 1'b0;
               busy      <= 1'b0;
               idx       <= {NB_ADDR{1'b0}};
               state     <= ST_IDLE;
            end
            default: begin
               state     <= ST_IDLE;
               idx       <= {NB_ADDR{1'b0}};
               stall_req <= 1'b0;
               busy      <= 1'b0;
               valid     <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the MIPS register file write port and read port 1 between the
// pipeline and the debug unit. Debug writes exist only with REGFILE_ARB_DBG_WRITE_EN.
module regfile_arbiter
   import regfile_arbiter_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_ADDR = NB_ADDR_DEF,
   parameter int N_REGS  = N_REGS_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wb_reg_write,
   input  logic [NB_ADDR-1:0] wb_write_register,
   input  logic [NB_DATA-1:0] wb_write_data,
   input  logic [NB_ADDR-1:0] id_read_register_1,
   output logic [NB_DATA-1:0] id_read_data_1,
   output logic               stall_req,
   input  logic               stall_ack,
   regfile_arbiter_if.slave   dbg,
   output logic               rf_RegWrite,
   output logic [NB_ADDR-1:0] rf_write_register,
   output logic [NB_DATA-1:0] rf_write_data,
   output logic [NB_ADDR-1:0] rf_read_register_1,
   input  logic [NB_DATA-1:0] rf_read_data_1
);

   logic               fsm_busy;
   logic               fsm_valid;
   logic               fsm_done;
   logic               fsm_idle;
   logic               dump_read;
   logic [NB_ADDR-1:0] dump_idx;
   logic [NB_ADDR-1:0] dump_addr;
   logic [NB_DATA-1:0] dump_data;
   logic               wr_en;

   regfile_dump_fsm #(
      .NB_DATA (NB_DATA),
      .NB_ADDR (NB_ADDR),
      .N_REGS  (N_REGS)
   ) u_dump_fsm (
      .clk          (clk),
      .reset        (reset),
      .stall_ack    (stall_ack),
      .dump_start   (dbg.dbg_dump_start),
      .ready        (dbg.dbg_ready),
      .rf_read_data (rf_read_data_1),
      .stall_req    (stall_req),
      .busy         (fsm_busy),
      .valid        (fsm_valid),
      .done         (fsm_done),
      .idle         (fsm_idle),
      .dump_read    (dump_read),
      .idx          (dump_idx),
      .addr         (dump_addr),
      .data         (dump_data)
   );

   assign dbg.dbg_busy  = fsm_busy;
   assign dbg.dbg_valid = fsm_valid;
   assign dbg.dbg_done  = fsm_done;
   assign dbg.dbg_addr  = dump_addr;
   assign dbg.dbg_data  = dump_data;

   assign id_read_data_1     = rf_read_data_1;
   assign rf_read_register_1 = dump_read ? dump_idx : id_read_register_1;

`ifdef REGFILE_ARB_DBG_WRITE_EN
   logic dbg_grant;
   logic wr_ack;

   // Write port mux: WB first, debug write only in an idle cycle with no WB write.
   always_comb begin
      rf_write_register = wb_write_register;
      rf_write_data     = wb_write_data;
      wr_en             = wb_reg_write;
      dbg_grant         = 1'b0;
      // The ack cycle blocks a re-grant while the requester is still dropping req.
      if (!wb_reg_write && dbg.dbg_wr_req && fsm_idle && !wr_ack) begin
         rf_write_register = dbg.dbg_wr_addr;
         rf_write_data     = dbg.dbg_wr_data;
         wr_en             = 1'b1;
         dbg_grant         = 1'b1;
      end else begin
         dbg_grant         = 1'b0;
      end
      rf_RegWrite = wr_en && write_allowed(32'(rf_write_register));
   end

   // Acknowledge lands the cycle after the debug write hits the regfile.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ack <= 1'b0;
      end else begin
         wr_ack <= dbg_grant;
      end
   end

   assign dbg.dbg_wr_ack = wr_ack;
`else
   // Write port carries WB only; r0 writes are suppressed.
   always_comb begin
      rf_write_register = wb_write_register;
      rf_write_data     = wb_write_data;
      wr_en             = wb_reg_write;
      rf_RegWrite       = wr_en && write_allowed(32'(rf_write_register));
   end
`endif

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter: a behavioural regfile, directed dumps,
// and a negedge monitor that checks every handshaked word against a queue.
module tb_regfile_arbiter;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } word_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        wb_reg_write = 1'b0;
   logic [4:0]  wb_write_register = 5'd0;
   logic [31:0] wb_write_data = 32'd0;
   logic [4:0]  id_read_register_1 = 5'd0;
   logic [31:0] id_read_data_1;
   logic        stall_req;
   logic        stall_ack = 1'b0;
   logic        rf_RegWrite;
   logic [4:0]  rf_write_register;
   logic [31:0] rf_write_data;
   logic [4:0]  rf_read_register_1;
   logic [31:0] rf_read_data_1;

   logic [31:0] rf_mem [32];
   logic [31:0] exp_mem [32];
   int          preload_mode = 0;
   word_t       exp_q [$];
   int          n_vec = 0;
   int          n_err = 0;
   int          done_cnt = 0;

   regfile_arbiter_if #(.NB_DATA(32), .NB_ADDR(5)) dbg ();

   regfile_arbiter dut (
      .clk                (clk),
      .reset              (reset),
      .wb_reg_write       (wb_reg_write),
      .wb_write_register  (wb_write_register),
      .wb_write_data      (wb_write_data),
      .id_read_register_1 (id_read_register_1),
      .id_read_data_1     (id_read_data_1),
      .stall_req          (stall_req),
      .stall_ack          (stall_ack),
      .dbg                (dbg),
      .rf_RegWrite        (rf_RegWrite),
      .rf_write_register  (rf_write_register),
      .rf_write_data      (rf_write_data),
      .rf_read_register_1 (rf_read_register_1),
      .rf_read_data_1     (rf_read_data_1)
   );

   always #5 clk = ~clk;

   // Behavioural register file with a bench-controlled bulk preload.
   always @(posedge clk) begin
      if (preload_mode != 0) begin
         for (int i = 0; i < 32; i++) begin
            rf_mem[i] <= (preload_mode == 2 && i == 0) ? 32'd0 : 32'h100 + 32'(i);
         end
      end else if (rf_RegWrite) begin
         rf_mem[rf_write_register] <= rf_write_data;
      end
   end
   assign rf_read_data_1 = rf_mem[rf_read_register_1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted word must match the head of the expectation queue.
   always @(negedge clk) begin
      if (reset && dbg.dbg_valid && dbg.dbg_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(dbg.dbg_addr), 32'hDEAD_BEEF);
         end else begin
            word_t e;
            e = exp_q.pop_front();
            chk("dump_addr", 32'(dbg.dbg_addr), 32'(e.addr));
            chk("dump_data", dbg.dbg_data, e.data);
         end
      end
      if (dbg.dbg_done) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input int mode);
      preload_mode = mode;
      tick();
      preload_mode = 0;
      for (int i = 0; i < 32; i++) exp_mem[i] = 32'h100 + 32'(i);
      if (mode == 2) exp_mem[0] = 32'd0;
   endtask

   task automatic do_dump(input int bp_addr, input int abort_addr, input bit extra_start);
      int  cyc;
      bit  fin;
      bit  aborted;
      int  bp;
      int  done_before;
      bp = bp_addr;
      fin = 1'b0;
      aborted = 1'b0;
      cyc = 0;
      done_before = done_cnt;
      for (int i = 0; i < 32; i++) exp_q.push_back('{addr: 5'(i), data: exp_mem[i]});
      dbg.dbg_ready = 1'b1;
      dbg.dbg_dump_start = 1'b1;
      tick();
      dbg.dbg_dump_start = 1'b0;
      chk("stall_req_on_start", 32'(stall_req), 32'd1);
      repeat (3) tick();
      chk("stall_req_wait_ack", 32'(stall_req), 32'd1);
      chk("busy_wait_ack", 32'(dbg.dbg_busy), 32'd1);
      chk("valid_before_ack", 32'(dbg.dbg_valid), 32'd0);
      stall_ack = 1'b1;
      while (!fin && cyc < 400) begin
         tick();
         cyc++;
         dbg.dbg_dump_start = 1'b0;
         if (abort_addr >= 0 && dbg.dbg_valid && int'(dbg.dbg_addr) == abort_addr) begin
            reset = 1'b0;
            #1;
            chk("abort_stall_req", 32'(stall_req), 32'd0);
            chk("abort_valid", 32'(dbg.dbg_valid), 32'd0);
            chk("abort_busy", 32'(dbg.dbg_busy), 32'd0);
            stall_ack = 1'b0;
            exp_q.delete();
            repeat (2) tick();
            reset = 1'b1;
            tick();
            chk("abort_no_done", 32'(done_cnt), 32'(done_before));
            fin = 1'b1;
            aborted = 1'b1;
         end else if (bp >= 0 && dbg.dbg_valid && int'(dbg.dbg_addr) == bp) begin
            dbg.dbg_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               tick();
               chk("bp_valid", 32'(dbg.dbg_valid), 32'd1);
               chk("bp_addr", 32'(dbg.dbg_addr), 32'(bp));
               chk("bp_data", dbg.dbg_data, exp_mem[bp]);
               chk("bp_read_mux", 32'(rf_read_register_1), 32'(bp));
            end
            dbg.dbg_ready = 1'b1;
            bp = -1;
         end else if (extra_start && dbg.dbg_valid && dbg.dbg_addr == 5'd3) begin
            dbg.dbg_dump_start = 1'b1;
            extra_start = 1'b0;
         end else if (dbg.dbg_done) begin
            chk("stall_req_in_done", 32'(stall_req), 32'd1);
            fin = 1'b1;
         end
      end
      if (!fin) chk("dump_timeout", 32'(cyc), 32'd0);
      if (!aborted) begin
         tick();
         chk("done_pulse_end", 32'(dbg.dbg_done), 32'd0);
         chk("stall_req_released", 32'(stall_req), 32'd0);
         chk("busy_released", 32'(dbg.dbg_busy), 32'd0);
         stall_ack = 1'b0;
         repeat (3) tick();
         chk("single_done", 32'(done_cnt), 32'(done_before + 1));
         chk("all_words_seen", 32'(exp_q.size()), 32'd0);
      end
   endtask

   initial begin
      dbg.dbg_dump_start = 1'b0;
      dbg.dbg_ready = 1'b0;
`ifdef REGFILE_ARB_DBG_WRITE_EN
      dbg.dbg_wr_req = 1'b0;
      dbg.dbg_wr_addr = 5'd0;
      dbg.dbg_wr_data = 32'd0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_stall_req", 32'(stall_req), 32'd0);
      chk("rst_busy", 32'(dbg.dbg_busy), 32'd0);
      chk("rst_valid", 32'(dbg.dbg_valid), 32'd0);
      chk("rst_done", 32'(dbg.dbg_done), 32'd0);
      chk("rst_addr", 32'(dbg.dbg_addr), 32'd0);
      chk("rst_data", dbg.dbg_data, 32'd0);
      reset = 1'b1;
      tick();
      preload(1);

      // Pipeline read path while idle.
      id_read_register_1 = 5'd5;
      #1;
      chk("id_read_mux", 32'(rf_read_register_1), 32'd5);
      chk("id_read_data", id_read_data_1, 32'h105);

      do_dump(-1, -1, 1'b0);          // full dump
      do_dump(7, -1, 1'b0);           // backpressure at r7

      // r2 write passes, r0 write is filtered.
      preload(2);
      wb_reg_write = 1'b1;
      wb_write_register = 5'd2;
      wb_write_data = 32'hFFFF_FFFF;
      #1;
      chk("wb_r2_regwrite", 32'(rf_RegWrite), 32'd1);
      chk("wb_r2_addr", 32'(rf_write_register), 32'd2);
      tick();
      wb_write_register = 5'd0;
      wb_write_data = 32'h1234;
      #1;
      chk("wb_r0_regwrite", 32'(rf_RegWrite), 32'd0);
      tick();
      wb_reg_write = 1'b0;
      exp_mem[2] = 32'hFFFF_FFFF;
      do_dump(-1, -1, 1'b0);

      preload(1);
      do_dump(-1, 12, 1'b0);          // abort at r12
      do_dump(-1, -1, 1'b0);          // restart from r0
      do_dump(-1, -1, 1'b1);          // start pulse during HOLD ignored

`ifdef REGFILE_ARB_DBG_WRITE_EN
      wb_reg_write = 1'b1;
      wb_write_register = 5'd6;
      wb_write_data = 32'h66;
      dbg.dbg_wr_req = 1'b1;
      dbg.dbg_wr_addr = 5'd5;
      dbg.dbg_wr_data = 32'hA5;
      #1;
      chk("wr_wb_first_addr", 32'(rf_write_register), 32'd6);
      chk("wr_wb_first_en", 32'(rf_RegWrite), 32'd1);
      tick();
      wb_reg_write = 1'b0;
      #1;
      chk("wr_dbg_addr", 32'(rf_write_register), 32'd5);
      chk("wr_dbg_data", rf_write_data, 32'hA5);
      chk("wr_dbg_en", 32'(rf_RegWrite), 32'd1);
      chk("wr_ack_early", 32'(dbg.dbg_wr_ack), 32'd0);
      tick();
      chk("wr_ack", 32'(dbg.dbg_wr_ack), 32'd1);
      chk("wr_no_regrant", 32'(rf_RegWrite), 32'd0);
      dbg.dbg_wr_req = 1'b0;
      tick();
      chk("wr_ack_pulse", 32'(dbg.dbg_wr_ack), 32'd0);
      exp_mem[5] = 32'hA5;
      exp_mem[6] = 32'h66;
      do_dump(-1, -1, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
